// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx: serial audio transmitter for I2S, left-justified,
// right-justified and TDM (DSP mode A) formats.
// The bit rate comes from a fractional phase accumulator clocked by clk_sys,
// so any clk_sys frequency yields an exact long-term frame rate.
// Ports:
//   clk_sys    system clock, all logic on its rising edge
//   reset      synchronous active-high reset
//   mode       0 = I2S, 1 = LJ, 2 = RJ, 3 = TDM (taken at frame start)
//   samples    CHANNELS x AUDIO_DW two's complement samples, channel c at [c*AUDIO_DW +: AUDIO_DW]
//   sample_req one-cycle pulse when samples/mode are captured
//   sclk       bit clock
//   lrclk      word select (stereo) or frame sync pulse (TDM)
//   sdata      serial data, MSB first
module i2s_tdm_tx #(
    parameter int unsigned CLK_RATE   = 50000000,
    parameter int unsigned AUDIO_RATE = 48000,
    parameter int unsigned AUDIO_DW   = 16,
    parameter int unsigned SLOT_W     = 32,
    parameter int unsigned CHANNELS   = 8
) (
    input  logic                         clk_sys,
    input  logic                         reset,
    input  logic [1:0]                   mode,
    input  logic [CHANNELS*AUDIO_DW-1:0] samples,
    output logic                         sample_req,
    output logic                         sclk,
    output logic                         lrclk,
    output logic                         sdata
);

    localparam int unsigned     AW        = $clog2(64'(2) * 64'(CLK_RATE));
    localparam int unsigned     SW        = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
    localparam int unsigned     CW        = $clog2(CHANNELS);
    localparam int unsigned     BW        = CHANNELS * AUDIO_DW;
    localparam longint unsigned INC_ST_L  = 64'(2) * 64'(AUDIO_RATE) * 64'(SLOT_W) * 64'(2);
    localparam longint unsigned INC_TDM_L = 64'(2) * 64'(AUDIO_RATE) * 64'(SLOT_W) * 64'(CHANNELS);
    localparam logic [AW-1:0]   INC_ST    = AW'(INC_ST_L);
    localparam logic [AW-1:0]   INC_TDM   = AW'(INC_TDM_L);
    localparam logic [AW-1:0]   CLK_R     = AW'(CLK_RATE);

    // Reject parameter sets the accumulator or slot layout cannot support
    if ((INC_ST_L > 64'(CLK_RATE)) || (INC_TDM_L > 64'(CLK_RATE)) ||
        (AUDIO_DW > SLOT_W) || (CHANNELS < 2)) begin : g_bad_cfg
        $error("i2s_tdm_tx: parameter set violates rate or width limits");
    end

    logic [AW-1:0] acc_q,   acc_d;
    logic          sclk_q,  sclk_d;
    logic          lrclk_q, lrclk_d;
    logic          sdata_q, sdata_d;
    logic          req_q,   req_d;
    logic          dly_q,   dly_d;
    logic [1:0]    mode_q,  mode_d;
    logic [BW-1:0] buf_q,   buf_d;
    logic [CW-1:0] slot_q,  slot_d;
    logic [SW-1:0] bit_q,   bit_d;

    logic [AW-1:0]       inc_c;
    logic [AW-1:0]       sum_c;
    logic                tick_c;
    logic                fall_c;
    logic                start_c;
    logic [1:0]          emode_c;
    logic [BW-1:0]       ebuf_c;
    logic [AUDIO_DW-1:0] smp_c;
    logic                lj_bit_c;
    logic                rj_bit_c;
    logic                d_bit_c;
    logic                dly_out_c;
    logic                last_slot_c;

    // Phase accumulator: step size follows the active (latched) mode
    always_comb begin
        inc_c  = (mode_q == 2'd3) ? INC_TDM : INC_ST;
        sum_c  = acc_q + inc_c;
        tick_c = (sum_c >= CLK_R);
    end

    // At frame start the incoming mode/samples are used directly for p = 0
    always_comb begin
        fall_c  = tick_c & sclk_q;
        start_c = fall_c && (slot_q == '0) && (bit_q == '0);
        emode_c = start_c ? mode : mode_q;
        ebuf_c  = start_c ? samples : buf_q;
    end

    // Undelayed slot bit D(p) for the current slot/bit position
    always_comb begin
        smp_c    = '0;
        lj_bit_c = 1'b0;
        rj_bit_c = 1'b0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (slot_q == CW'(c)) begin
                smp_c = ebuf_c[c*AUDIO_DW +: AUDIO_DW];
            end
        end
        for (int unsigned k = 0; k < AUDIO_DW; k++) begin
            if (bit_q == SW'(AUDIO_DW - 1 - k)) begin
                lj_bit_c = smp_c[k];
            end
            if (bit_q == SW'(SLOT_W - 1 - k)) begin
                rj_bit_c = smp_c[k];
            end
        end
        d_bit_c = (emode_c == 2'd2) ? rj_bit_c : lj_bit_c;
    end

    // Next-state logic for clock, framing, data and position pointer
    always_comb begin
        acc_d       = tick_c ? (sum_c - CLK_R) : sum_c;
        sclk_d      = sclk_q;
        lrclk_d     = lrclk_q;
        sdata_d     = sdata_q;
        req_d       = 1'b0;
        dly_d       = dly_q;
        mode_d      = mode_q;
        buf_d       = buf_q;
        slot_d      = slot_q;
        bit_d       = bit_q;
        // A mode change empties the delay flop, so the first delayed bit is 0
        dly_out_c   = (start_c && (mode != mode_q)) ? 1'b0 : dly_q;
        last_slot_c = (emode_c == 2'd3) ? (slot_q == CW'(CHANNELS - 1)) : (slot_q == CW'(1));

        if (tick_c) begin
            sclk_d = ~sclk_q;
        end

        if (fall_c) begin
            if (start_c) begin
                mode_d = mode;
                buf_d  = samples;
                req_d  = 1'b1;
            end
            dly_d = d_bit_c;
            case (emode_c)
                2'd0: begin
                    lrclk_d = (slot_q == CW'(1));
                    sdata_d = dly_out_c;
                end
                2'd3: begin
                    lrclk_d = start_c;
                    sdata_d = dly_out_c;
                end
                default: begin
                    lrclk_d = (slot_q == '0);
                    sdata_d = d_bit_c;
                end
            endcase
            if (bit_q == SW'(SLOT_W - 1)) begin
                bit_d  = '0;
                slot_d = last_slot_c ? '0 : (slot_q + CW'(1));
            end else begin
                bit_d  = bit_q + SW'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            acc_q   <= '0;
            sclk_q  <= 1'b1;
            lrclk_q <= 1'b0;
            sdata_q <= 1'b0;
            req_q   <= 1'b0;
            dly_q   <= 1'b0;
            mode_q  <= 2'd0;
            buf_q   <= '0;
            slot_q  <= '0;
            bit_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            sclk_q  <= sclk_d;
            lrclk_q <= lrclk_d;
            sdata_q <= sdata_d;
            req_q   <= req_d;
            dly_q   <= dly_d;
            mode_q  <= mode_d;
            buf_q   <= buf_d;
            slot_q  <= slot_d;
            bit_q   <= bit_d;
        end
    end

    assign sample_req = req_q;
    assign sclk       = sclk_q;
    assign lrclk      = lrclk_q;
    assign sdata      = sdata_q;

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// tb_i2s_tdm_tx: randomized scoreboard bench for i2s_tdm_tx.
// Each frame's expected (lrclk, sdata) sequence is built from the format
// rules and queued when the frame's mode/samples are driven; a monitor pops
// one entry per falling sclk edge and also checks tick spacing and rate.
module tb_i2s_tdm_tx;

    localparam int unsigned     CLK_RATE   = 50000000;
    localparam int unsigned     AUDIO_RATE = 48000;
    localparam int unsigned     AUDIO_DW   = 16;
    localparam int unsigned     SLOT_W     = 32;
    localparam int unsigned     CHANNELS   = 8;
    localparam longint unsigned INC_ST     = 64'(2) * AUDIO_RATE * SLOT_W * 2;
    localparam longint unsigned INC_TDM    = 64'(2) * AUDIO_RATE * SLOT_W * CHANNELS;
    localparam int              RATE_WIN   = 3000;

    logic                         clk_sys = 1'b0;
    logic                         reset   = 1'b1;
    logic [1:0]                   mode    = 2'd0;
    logic [CHANNELS*AUDIO_DW-1:0] samples = '0;
    logic                         sample_req;
    logic                         sclk;
    logic                         lrclk;
    logic                         sdata;

    i2s_tdm_tx #(
        .CLK_RATE   (CLK_RATE),
        .AUDIO_RATE (AUDIO_RATE),
        .AUDIO_DW   (AUDIO_DW),
        .SLOT_W     (SLOT_W),
        .CHANNELS   (CHANNELS)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .mode       (mode),
        .samples    (samples),
        .sample_req (sample_req),
        .sclk       (sclk),
        .lrclk      (lrclk),
        .sdata      (sdata)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int p;
        bit lr;
        bit sd;
        bit tdm;
    } exp_t;

    exp_t                exp_q[$];
    int                  n_cmp     = 0;
    int                  n_err     = 0;
    int                  prev_mode = 0;
    bit                  prev_last = 1'b0;
    int                  cur_p     = -1;
    logic [AUDIO_DW-1:0] smp [CHANNELS];

    int modes_a[12] = '{0, 2, 1, 3, 3, 0, 0, 3, 2, 1, 1, 0};
    int modes_b[6]  = '{1, 0, 2, 3, 0, 3};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Slot bit as defined by the format: MSB-first, left or right aligned
    function automatic bit d_bit(input int m, input logic [AUDIO_DW-1:0] s, input int b);
        int unsigned v;
        v = 32'(s);
        if (m == 2) begin
            if (b >= int'(SLOT_W - AUDIO_DW)) return ((v >> (int'(SLOT_W) - 1 - b)) & 1) != 0;
            return 1'b0;
        end
        if (b < int'(AUDIO_DW)) return ((v >> (int'(AUDIO_DW) - 1 - b)) & 1) != 0;
        return 1'b0;
    endfunction

    // Build and queue the full expected frame for mode m and samples in smp
    task automatic push_frame(input int m);
        int   n;
        int   f;
        int   slot;
        int   b;
        exp_t e;
        n = (m == 3) ? int'(CHANNELS) : 2;
        f = n * int'(SLOT_W);
        for (int p = 0; p < f; p++) begin
            slot  = p / int'(SLOT_W);
            b     = p % int'(SLOT_W);
            e.p   = p;
            e.tdm = (m == 3);
            case (m)
                0:       e.lr = (slot == 1);
                3:       e.lr = (p == 0);
                default: e.lr = (slot == 0);
            endcase
            if (m == 0 || m == 3) begin
                if (p == 0) e.sd = (m == prev_mode) ? prev_last : 1'b0;
                else        e.sd = d_bit(m, smp[(p - 1) / int'(SLOT_W)], (p - 1) % int'(SLOT_W));
            end else begin
                e.sd = d_bit(m, smp[slot], b);
            end
            exp_q.push_back(e);
        end
        prev_last = d_bit(m, smp[n - 1], int'(SLOT_W) - 1);
        prev_mode = m;
    endtask

    task automatic apply_frame(input int m, input bit directed, input logic [15:0] d0, input logic [15:0] d1);
        for (int c = 0; c < int'(CHANNELS); c++) smp[c] = AUDIO_DW'($urandom);
        if (directed) begin
            smp[0] = d0;
            smp[1] = d1;
        end
        for (int c = 0; c < int'(CHANNELS); c++) samples[c*AUDIO_DW +: AUDIO_DW] = smp[c];
        mode = 2'(m);
        push_frame(m);
    endtask

    // Garbage on the inputs mid-frame must not reach the output
    task automatic scramble();
        mode = 2'($urandom);
        for (int c = 0; c < int'(CHANNELS); c++) samples[c*AUDIO_DW +: AUDIO_DW] = AUDIO_DW'($urandom);
    endtask

    task automatic wait_req();
        int t;
        t = 0;
        do begin
            @(negedge clk_sys);
            t++;
        end while (sample_req !== 1'b1 && t < 3000);
        check("sample_req_seen", 64'(sample_req), 64'd1);
    endtask

    // ---------------- monitor ----------------
    logic            rst_seen;
    bit              prev_sclk  = 1'b1;
    bit              prev_lr    = 1'b0;
    bit              prev_sd    = 1'b0;
    int              cyc        = 0;
    int              toggles    = 0;
    int              gap        = 0;
    bit              have_tick  = 1'b0;
    bit              have_frame = 1'b0;
    bit              cur_tdm    = 1'b0;
    bit              prev_tdm   = 1'b0;
    exp_t            mon_e;
    longint unsigned mon_inc;
    longint unsigned gap_lo;
    longint unsigned gap_hi;

    always @(posedge clk_sys) rst_seen <= reset;

    always @(negedge clk_sys) begin
        if (rst_seen === 1'b1) begin
            check("reset_out", 64'({sclk, lrclk, sdata, sample_req}), 64'h8);
            prev_sclk  = 1'b1;
            prev_lr    = 1'b0;
            prev_sd    = 1'b0;
            cyc        = 0;
            toggles    = 0;
            gap        = 0;
            have_tick  = 1'b0;
            have_frame = 1'b0;
            cur_p      = -1;
        end else if (rst_seen === 1'b0) begin
            cyc++;
            gap++;
            if (sclk !== prev_sclk) begin
                toggles++;
                if (have_tick && cur_tdm == prev_tdm) begin
                    mon_inc = cur_tdm ? INC_TDM : INC_ST;
                    gap_lo  = CLK_RATE / mon_inc;
                    gap_hi  = gap_lo + (((CLK_RATE % mon_inc) != 0) ? 1 : 0);
                    n_cmp++;
                    if (gap < gap_lo || gap > gap_hi) begin
                        n_err++;
                        $display("FAIL tick_gap: got %0d cycles expected %0d..%0d at %0t",
                                 gap, gap_lo, gap_hi, $time);
                    end
                end
                have_tick = 1'b1;
                gap       = 0;
            end
            if (sclk !== prev_sclk && sclk === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL fall_underflow: got falling sclk expected none at %0t", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.p == 0) begin
                        prev_tdm   = have_frame ? cur_tdm : mon_e.tdm;
                        cur_tdm    = mon_e.tdm;
                        have_frame = 1'b1;
                    end
                    cur_p = mon_e.p;
                    check($sformatf("lrclk_p%0d", mon_e.p), 64'(lrclk), 64'(mon_e.lr));
                    check($sformatf("sdata_p%0d", mon_e.p), 64'(sdata), 64'(mon_e.sd));
                    check("sample_req_fall", 64'(sample_req), 64'(mon_e.p == 0));
                end
            end else begin
                check("hold", 64'({lrclk, sdata, sample_req}), 64'({prev_lr, prev_sd, 1'b0}));
            end
            if (cyc == RATE_WIN) begin
                check("tick_count", 64'(toggles), 64'((longint'(RATE_WIN) * INC_ST) / CLK_RATE));
            end
            prev_sclk = sclk;
            prev_lr   = lrclk;
            prev_sd   = sdata;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int t;
        apply_frame(modes_a[0], 1'b1, 16'h8001, 16'h7FFE);
        repeat (4) @(negedge clk_sys);
        reset = 1'b0;
        for (int i = 1; i < 12; i++) begin
            wait_req();
            scramble();
            repeat (200) @(negedge clk_sys);
            if (i <= 2) apply_frame(modes_a[i], 1'b1, 16'hA5A5, 16'($urandom));
            else        apply_frame(modes_a[i], 1'b0, 16'h0, 16'h0);
        end
        wait_req();

        // Reset in the middle of a frame, then restart cleanly
        t = 0;
        while (cur_p != 40 && t < 2000) begin
            @(negedge clk_sys);
            t++;
        end
        check("reach_p40", 64'(cur_p), 64'd40);
        @(negedge clk_sys);
        reset = 1'b1;
        exp_q.delete();
        prev_mode = 0;
        prev_last = 1'b0;
        repeat (3) @(negedge clk_sys);
        apply_frame(modes_b[0], 1'b0, 16'h0, 16'h0);
        reset = 1'b0;
        for (int i = 1; i < 6; i++) begin
            wait_req();
            scramble();
            repeat (200) @(negedge clk_sys);
            apply_frame(modes_b[i], 1'b0, 16'h0, 16'h0);
        end
        wait_req();

        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk_sys);
            t++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: still running at %0t expected finish before 5000000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
